sd_write_scheduler: RTL and testbench

- Sequences the SD-card SPI datapath for the UART-to-SD logging path.
- Runs the card initializer once, then watches the receive FIFO fill level and launches the block writer once for every full block.
- Advances the target sector after each block and owns the shared MOSI/CS mux.
- Sits between the top-level start/flush controls, the FIFO count output, the SDCardInitializer and the SDWriter, all in the SPI clock domain.

---
 rtl/sd_write_scheduler.sv | 139 +++++++++++++
 tb/tb_sd_write_scheduler.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/sd_write_scheduler.sv
// sd_write_scheduler: runs the SD initializer, then launches one block write per full FIFO block.
// Optional macro SD_WRITE_RETRY_EN retries a failed block up to 3 times before ERROR.
module sd_write_scheduler #(
    parameter int unsigned BLOCK_BYTES  = 512,
    parameter int unsigned COUNT_WIDTH  = 10,
    parameter logic [31:0] START_SECTOR = 32'd0,
    parameter int unsigned MAX_BLOCKS   = 0,
    parameter int unsigned INIT_TIMEOUT = 65535,
    parameter int unsigned ACK_TIMEOUT  = 15
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_start,
    input  logic                   i_flush,
    output logic                   o_init_start,
    input  logic                   i_init_ready,
    input  logic                   i_init_mosi,
    input  logic                   i_init_cs,
    output logic                   o_wr_start,
    output logic [31:0]            o_32_wr_sector,
    output logic                   o_wr_pad,
    input  logic                   i_wr_busy,
    input  logic                   i_wr_error,
    input  logic                   i_wr_mosi,
    input  logic                   i_wr_cs,
    input  logic [COUNT_WIDTH-1:0] i_fifo_data_count,
    output logic                   o_mosi,
    output logic                   o_cs,
    output logic                   o_busy,
    output logic                   o_done,
    output logic                   o_error,
    output logic [15:0]            o_16_blocks,
    output logic [7:0]             o_8_status
);
    typedef enum logic [3:0] {
        IDLE = 4'd0, INIT_START = 4'd1, INIT_WAIT = 4'd2, WAIT_DATA = 4'd3,
        WR_START = 4'd4, WR_ACK = 4'd5, WR_WAIT = 4'd6, DONE = 4'd7, ERROR = 4'd8
    } state_t;

    state_t      state_q, state_d, fail_st;
    logic [31:0] timer_q, timer_d, sector_q, sector_d;
    logic [15:0] blocks_q, blocks_d, blocks_inc;
    logic        pad_q, pad_d, flush_q, flush_d, mosi_q, mosi_d, cs_q, cs_d;
    logic        count_full, count_nz, init_to, ack_to, blk_ok, max_hit, active, init_path, wr_path;

    assign count_full = 32'(i_fifo_data_count) >= 32'(BLOCK_BYTES);
    assign count_nz   = |i_fifo_data_count;
    assign init_to    = timer_q >= 32'(INIT_TIMEOUT) - 32'd1;
    assign ack_to     = timer_q >= 32'(ACK_TIMEOUT) - 32'd1;
    assign blk_ok     = state_q == WR_WAIT && !i_wr_busy && !i_wr_error;
    assign blocks_inc = (blocks_q == 16'hFFFF) ? blocks_q : blocks_q + 16'd1;
    assign max_hit    = (MAX_BLOCKS != 0) && ({16'd0, blocks_inc} == 32'(MAX_BLOCKS));
    assign active     = state_q != IDLE && state_q != DONE && state_q != ERROR;
    assign init_path  = state_q == INIT_START || state_q == INIT_WAIT;
    assign wr_path    = state_q == WR_START || state_q == WR_ACK || state_q == WR_WAIT;

`ifdef SD_WRITE_RETRY_EN
    logic [1:0] retry_q, retry_d;
    logic       blk_fail;
    assign blk_fail = (state_q == WR_WAIT && !i_wr_busy && i_wr_error) ||
                      (state_q == WR_ACK && !i_wr_busy && ack_to);
    assign fail_st  = (retry_q == 2'd3) ? ERROR : WR_START;
    assign retry_d  = blk_ok ? 2'd0 : (blk_fail && retry_q != 2'd3) ? retry_q + 2'd1 : retry_q;
    always_ff @(posedge i_clk or posedge i_reset)
        if (i_reset) retry_q <= 2'd0;
        else         retry_q <= retry_d;
`else
    assign fail_st = ERROR;
`endif

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q  <= IDLE;
            timer_q  <= 32'd0;
            sector_q <= START_SECTOR;
            blocks_q <= 16'd0;
            pad_q    <= 1'b0;
            flush_q  <= 1'b0;
            mosi_q   <= 1'b1;
            cs_q     <= 1'b1;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            sector_q <= sector_d;
            blocks_q <= blocks_d;
            pad_q    <= pad_d;
            flush_q  <= flush_d;
            mosi_q   <= mosi_d;
            cs_q     <= cs_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:       state_d = i_start ? INIT_START : IDLE;
            INIT_START: state_d = INIT_WAIT;
            INIT_WAIT:  state_d = i_init_ready ? WAIT_DATA : init_to ? ERROR : INIT_WAIT;
            WAIT_DATA:  state_d = (count_full || (flush_q && count_nz)) ? WR_START :
                                  flush_q ? DONE : WAIT_DATA;
            WR_START:   state_d = WR_ACK;
            WR_ACK:     state_d = i_wr_busy ? WR_WAIT : ack_to ? fail_st : WR_ACK;
            WR_WAIT:    state_d = i_wr_busy ? WR_WAIT : i_wr_error ? fail_st :
                                  (pad_q || max_hit) ? DONE : WAIT_DATA;
            DONE:       state_d = DONE;
            ERROR:      state_d = ERROR;
            default:    state_d = ERROR;
        endcase
    end

    // Datapath next-state; a padded block is chosen only when no full block is available.
    always_comb begin
        timer_d  = (state_d == state_q && (state_q == INIT_WAIT || state_q == WR_ACK)) ? timer_q + 32'd1 : 32'd0;
        sector_d = blk_ok ? sector_q + 32'd1 : sector_q;
        blocks_d = blk_ok ? blocks_inc : blocks_q;
        pad_d    = (state_q == WAIT_DATA) ? (!count_full && flush_q && count_nz) : blk_ok ? 1'b0 : pad_q;
        flush_d  = (blk_ok && pad_q) ? 1'b0 : (i_flush && active) ? 1'b1 : flush_q;
        mosi_d   = init_path ? i_init_mosi : wr_path ? i_wr_mosi : 1'b1;
        cs_d     = init_path ? i_init_cs : wr_path ? i_wr_cs : 1'b1;
    end

    always_comb begin
        o_init_start   = state_q == INIT_START;
        o_wr_start     = state_q == WR_START;
        o_busy         = active;
        o_done         = state_q == DONE;
        o_error        = state_q == ERROR;
        o_32_wr_sector = sector_q;
        o_wr_pad       = pad_q;
        o_16_blocks    = blocks_q;
        o_mosi         = mosi_q;
        o_cs           = cs_q;
`ifdef SD_WRITE_RETRY_EN
        o_8_status     = {state_q == ERROR, state_q == DONE, retry_q != 2'd0, i_init_ready, state_q};
`else
        o_8_status     = {state_q == ERROR, state_q == DONE, flush_q, i_init_ready, state_q};
`endif
    end
endmodule

// File: tb/tb_sd_write_scheduler.sv
// tb_sd_write_scheduler: scoreboard bench; expected write launches are queued, a monitor checks each o_wr_start.
module tb_sd_write_scheduler;
    logic        clk = 1'b0, i_reset, i_start, i_flush, i_init_ready, i_init_mosi, i_init_cs;
    logic        i_wr_busy, i_wr_error, i_wr_mosi, i_wr_cs;
    logic [9:0]  i_fifo_data_count;
    logic        o_init_start, o_wr_start, o_wr_pad, o_mosi, o_cs, o_busy, o_done, o_error;
    logic [31:0] o_32_wr_sector;
    logic [15:0] o_16_blocks;
    logic [7:0]  o_8_status;

    int n_checks = 0, n_fail = 0, wr_cnt = 0, init_cnt = 0, busy_len = 10;
    logic wr_err = 1'b0, respond = 1'b1, drain = 1'b0, wr_active = 1'b0;
    logic [32:0] exp_q[$];

`ifdef SD_WRITE_RETRY_EN
    localparam int ATTEMPTS = 4;
`else
    localparam int ATTEMPTS = 1;
`endif

    sd_write_scheduler #(.BLOCK_BYTES(512), .COUNT_WIDTH(10), .START_SECTOR(32'd100),
                         .MAX_BLOCKS(3), .INIT_TIMEOUT(200), .ACK_TIMEOUT(15)) dut (
        .i_clk(clk), .i_reset(i_reset), .i_start(i_start), .i_flush(i_flush),
        .o_init_start(o_init_start), .i_init_ready(i_init_ready), .i_init_mosi(i_init_mosi),
        .i_init_cs(i_init_cs), .o_wr_start(o_wr_start), .o_32_wr_sector(o_32_wr_sector),
        .o_wr_pad(o_wr_pad), .i_wr_busy(i_wr_busy), .i_wr_error(i_wr_error), .i_wr_mosi(i_wr_mosi),
        .i_wr_cs(i_wr_cs), .i_fifo_data_count(i_fifo_data_count), .o_mosi(o_mosi), .o_cs(o_cs),
        .o_busy(o_busy), .o_done(o_done), .o_error(o_error), .o_16_blocks(o_16_blocks),
        .o_8_status(o_8_status));

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every launch must match the oldest queued expectation.
    initial forever begin
        logic [32:0] e;
        @(negedge clk);
        if (o_init_start) init_cnt++;
        if (o_wr_start) begin
            wr_cnt++;
            if (exp_q.size() == 0) check("wr_start_unexpected", 32'd1, 32'd0);
            else begin
                e = exp_q.pop_front();
                check("wr_sector", o_32_wr_sector, e[31:0]);
                check("wr_pad", 32'(o_wr_pad), 32'(e[32]));
            end
        end
    end

    // Writer model: busy two cycles after the start pulse, error reported on the busy fall.
    initial forever begin
        @(negedge clk);
        i_wr_error = 1'b0;
        if (o_wr_start && respond) begin
            wr_active = 1'b1;
            if (drain) i_fifo_data_count = 10'd0;
            repeat (2) @(negedge clk);
            i_wr_busy = 1'b1; i_wr_cs = 1'b0; i_wr_mosi = 1'b0;
            repeat (busy_len) @(negedge clk);
            i_wr_error = wr_err; i_wr_busy = 1'b0; i_wr_cs = 1'b1; i_wr_mosi = 1'b1;
            wr_active = 1'b0;
        end
    end

    task automatic do_reset();
        i_reset = 1'b1; i_start = 1'b0; i_flush = 1'b0; i_init_ready = 1'b0;
        i_init_mosi = 1'b1; i_init_cs = 1'b1; i_fifo_data_count = 10'd0;
        wr_err = 1'b0; respond = 1'b1; drain = 1'b0; busy_len = 10;
        for (int i = 0; i < 200 && wr_active; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        i_reset = 1'b0; wr_cnt = 0; init_cnt = 0;
        exp_q.delete();
        @(negedge clk);
    endtask

    task automatic pulse_start();
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        i_wr_busy = 1'b0; i_wr_error = 1'b0; i_wr_mosi = 1'b1; i_wr_cs = 1'b1;
        do_reset();
        check("rst_status", 32'(o_8_status), 32'h00);
        check("rst_cs_mosi", {30'd0, o_cs, o_mosi}, 32'd3);
        check("rst_sector", o_32_wr_sector, 32'd100);
        check("rst_blocks", 32'(o_16_blocks), 32'd0);
        check("rst_pulses", {29'd0, o_busy, o_init_start, o_wr_start}, 32'd0);

        // One full block, writer busy 50 cycles, FIFO drained by the write.
        i_fifo_data_count = 10'd512; drain = 1'b1; busy_len = 50;
        exp_q.push_back({1'b0, 32'd100});
        pulse_start();
        repeat (100) @(negedge clk);
        i_init_ready = 1'b1;
        for (int i = 0; i < 50 && !i_wr_busy; i++) @(negedge clk);
        repeat (5) @(negedge clk);
        check("t1_state_wr_wait", 32'(o_8_status[3:0]), 32'd6);
        check("t1_cs_from_writer", 32'(o_cs), 32'd0);
        for (int i = 0; i < 200 && o_16_blocks != 16'd1; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        check("t1_blocks", 32'(o_16_blocks), 32'd1);
        check("t1_state_wait_data", 32'(o_8_status[3:0]), 32'd3);
        check("t1_init_pulses", init_cnt, 32'd1);
        check("t1_wr_pulses", wr_cnt, 32'd1);
        check("t1_next_sector", o_32_wr_sector, 32'd101);
        check("t1_cs_idle", 32'(o_cs), 32'd1);
        check("t1_queue", exp_q.size(), 32'd0);

        // Block limit: three sectors then DONE.
        do_reset();
        i_fifo_data_count = 10'd512; i_init_ready = 1'b1;
        exp_q.push_back({1'b0, 32'd100}); exp_q.push_back({1'b0, 32'd101}); exp_q.push_back({1'b0, 32'd102});
        pulse_start();
        for (int i = 0; i < 500 && !o_done; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        check("t2_done", 32'(o_done), 32'd1);
        check("t2_wr_pulses", wr_cnt, 32'd3);
        check("t2_blocks", 32'(o_16_blocks), 32'd3);
        check("t2_sector", o_32_wr_sector, 32'd103);
        check("t2_busy", 32'(o_busy), 32'd0);
        check("t2_queue", exp_q.size(), 32'd0);

        // Partial block then flush: one padded write, then DONE.
        do_reset();
        i_fifo_data_count = 10'd200; i_init_ready = 1'b1; drain = 1'b1;
        pulse_start();
        repeat (20) @(negedge clk);
        check("t3_waiting", 32'(o_8_status[3:0]), 32'd3);
        check("t3_no_write", wr_cnt, 32'd0);
        exp_q.push_back({1'b1, 32'd100});
        i_flush = 1'b1;
        @(negedge clk);
        i_flush = 1'b0;
        for (int i = 0; i < 200 && !o_done; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        check("t3_status", 32'(o_8_status), 32'h57);
        check("t3_blocks", 32'(o_16_blocks), 32'd1);
        check("t3_wr_pulses", wr_cnt, 32'd1);
        check("t3_pad_cleared", 32'(o_wr_pad), 32'd0);
        check("t3_queue", exp_q.size(), 32'd0);

        // Initializer never ready: ERROR after the timeout; mux returns to idle levels.
        do_reset();
        i_init_cs = 1'b0; i_init_mosi = 1'b0;
        pulse_start();
        repeat (10) @(negedge clk);
        check("t4_init_wait", 32'(o_8_status[3:0]), 32'd2);
        check("t4_init_lines", {30'd0, o_cs, o_mosi}, 32'd0);
        repeat (140) @(negedge clk);
        check("t4_no_early_error", 32'(o_error), 32'd0);
        for (int i = 0; i < 100 && !o_error; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        check("t4_error", 32'(o_8_status), 32'h88);
        check("t4_lines_idle", {30'd0, o_cs, o_mosi}, 32'd3);
        check("t4_busy", 32'(o_busy), 32'd0);

        // Data-response error: one attempt, or four with retries, all on the same sector.
        do_reset();
        i_fifo_data_count = 10'd512; i_init_ready = 1'b1; wr_err = 1'b1;
        for (int i = 0; i < ATTEMPTS; i++) exp_q.push_back({1'b0, 32'd100});
        pulse_start();
        for (int i = 0; i < 400 && !o_error; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        check("t5_error", 32'(o_error), 32'd1);
        check("t5_wr_pulses", wr_cnt, ATTEMPTS);
        check("t5_blocks", 32'(o_16_blocks), 32'd0);
        check("t5_sector", o_32_wr_sector, 32'd100);
        check("t5_queue", exp_q.size(), 32'd0);

        // Writer never acknowledges: ACK timeout path.
        do_reset();
        i_fifo_data_count = 10'd512; i_init_ready = 1'b1; respond = 1'b0;
        for (int i = 0; i < ATTEMPTS; i++) exp_q.push_back({1'b0, 32'd100});
        pulse_start();
        for (int i = 0; i < 400 && !o_error; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        check("t6_error", 32'(o_error), 32'd1);
        check("t6_wr_pulses", wr_cnt, ATTEMPTS);
        check("t6_queue", exp_q.size(), 32'd0);

        // Asynchronous reset during the second write.
        do_reset();
        i_fifo_data_count = 10'd512; i_init_ready = 1'b1; busy_len = 30;
        exp_q.push_back({1'b0, 32'd100}); exp_q.push_back({1'b0, 32'd101});
        pulse_start();
        for (int i = 0; i < 300 && o_16_blocks != 16'd1; i++) @(negedge clk);
        for (int i = 0; i < 100 && o_8_status[3:0] != 4'd6; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        check("t7_in_wr_wait", 32'(o_8_status[3:0]), 32'd6);
        i_reset = 1'b1;
        #1;
        check("t7_state_idle", 32'(o_8_status[3:0]), 32'd0);
        check("t7_cs", 32'(o_cs), 32'd1);
        check("t7_sector", o_32_wr_sector, 32'd100);
        check("t7_blocks", 32'(o_16_blocks), 32'd0);
        check("t7_busy", 32'(o_busy), 32'd0);
        repeat (2) @(negedge clk);
        i_reset = 1'b0;
        for (int i = 0; i < 100 && wr_active; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        check("t7_stays_idle", 32'(o_8_status[3:0]), 32'd0);
        check("t7_wr_pulses", wr_cnt, 32'd2);
        check("t7_queue", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
